// File: rtl/ram_dp_clr.sv
// ram_dp_clr
// True dual-port synchronous RAM with a hardware clear engine.
// Port A serves the CPU and port B serves DMA/peripheral masters. After reset,
// or when clr is requested, every word is written to zero. While the clear
// engine runs, both ports are locked out and their read outputs are held at 0.
//
// Parameters:
//   DW   - data width in bits (1..36)
//   AW   - address width, depth N = 2**AW
//   OREG - 0: 1-cycle read latency, 1: extra output register (2 cycles)
//
// Ports:
//   clk      - master clock, rising edge
//   rst      - asynchronous active-high reset
//   clr      - synchronous request to re-clear the whole array
//   busy     - high while a clear is in progress (registered)
//   aa, ab   - port A / port B word address
//   dia, dib - port A / port B write data
//   cea, ceb - port enables
//   wea, web - port write enables, qualified by the matching enable
//   doa, dob - port A / port B read data
module ram_dp_clr #(
    parameter int DW   = 16,
    parameter int AW   = 14,
    parameter int OREG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    input  logic [AW-1:0] aa,
    input  logic [AW-1:0] ab,
    input  logic [DW-1:0] dia,
    input  logic [DW-1:0] dib,
    input  logic          cea,
    input  logic          ceb,
    input  logic          wea,
    input  logic          web,
    output logic [DW-1:0] doa,
    output logic [DW-1:0] dob
);

    localparam int N = 1 << AW;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic [DW-1:0] r_mem [N];
    logic [DW-1:0] r_rdA;
    logic [DW-1:0] r_rdB;

    logic          w_accA;
    logic          w_accB;
    logic          w_wrA;
    logic          w_wrB;
    logic          w_cntLast;

    // A user access happens only in IDLE and never on the edge that accepts
    // a clear request, so a write issued alongside clr is dropped.
    assign w_accA    = cea & ~r_busy & ~clr;
    assign w_accB    = ceb & ~r_busy & ~clr;
    assign w_wrA     = w_accA & wea;
    assign w_wrB     = w_accB & web;
    assign w_cntLast = &r_cnt;

    assign busy = r_busy;

    // Clear engine: walks r_cnt through every address once. busy mirrors the
    // CLEAR state but is kept as its own flop so it is a clean registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (w_cntLast) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array write port. Reset only suppresses writes; the contents themselves
    // are never reset here, the clear engine zeroes them afterwards. Port A is
    // written last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
            if (r_busy) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wrB) begin
                    r_mem[ab] <= dib;
                end
                if (w_wrA) begin
                    r_mem[aa] <= dia;
                end
            end
        end
    end

    // First read stage. The array is sampled before this edge's writes land,
    // which gives read-first behaviour on both the same and the opposite port.
    // During a clear the registers are forced to 0 so stale data disappears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdA <= '0;
            r_rdB <= '0;
        end else if (r_busy) begin
            r_rdA <= '0;
            r_rdB <= '0;
        end else begin
            if (w_accA) begin
                r_rdA <= r_mem[aa];
            end
            if (w_accB) begin
                r_rdB <= r_mem[ab];
            end
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] r_pipeA;
            logic [DW-1:0] r_pipeB;

            // Optional output stage: always enabled, cleared like the first stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipeA <= '0;
                    r_pipeB <= '0;
                end else if (r_busy) begin
                    r_pipeA <= '0;
                    r_pipeB <= '0;
                end else begin
                    r_pipeA <= r_rdA;
                    r_pipeB <= r_rdB;
                end
            end

            assign doa = r_pipeA;
            assign dob = r_pipeB;
        end else begin : g_noreg
            assign doa = r_rdA;
            assign dob = r_rdB;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr
// Directed bench for ram_dp_clr with DW = 16, AW = 4. Two instances share all
// inputs: one without and one with the output register, so the OREG = 1 copy
// must show each expected value one edge after the OREG = 0 copy.
module tb_ram_dp_clr;

    typedef struct packed {
        logic        cea;
        logic        wea;
        logic [3:0]  aa;
        logic [15:0] dia;
        logic        ceb;
        logic        web;
        logic [3:0]  ab;
        logic [15:0] dib;
        logic [15:0] expA;
        logic [15:0] expB;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        cea;
    logic        ceb;
    logic        wea;
    logic        web;
    logic [3:0]  aa;
    logic [3:0]  ab;
    logic [15:0] dia;
    logic [15:0] dib;

    logic        busy0;
    logic        busy1;
    logic [15:0] doa0;
    logic [15:0] dob0;
    logic [15:0] doa1;
    logic [15:0] dob1;

    int compCount = 0;
    int errCount  = 0;

    vec_t vecs [12];

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    ram_dp_clr #(.DW(16), .AW(4), .OREG(0)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .busy (busy0),
        .aa   (aa),
        .ab   (ab),
        .dia  (dia),
        .dib  (dib),
        .cea  (cea),
        .ceb  (ceb),
        .wea  (wea),
        .web  (web),
        .doa  (doa0),
        .dob  (dob0)
    );

    ram_dp_clr #(.DW(16), .AW(4), .OREG(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .busy (busy1),
        .aa   (aa),
        .ab   (ab),
        .dia  (dia),
        .dib  (dib),
        .cea  (cea),
        .ceb  (ceb),
        .wea  (wea),
        .web  (web),
        .doa  (doa1),
        .dob  (dob1)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        cea = 1'b0;
        wea = 1'b0;
        aa  = '0;
        dia = '0;
        ceb = 1'b0;
        web = 1'b0;
        ab  = '0;
        dib = '0;
    endtask

    // Drive one cycle of port traffic and clock it in.
    task automatic applyStimulus(input logic iCea, input logic iWea,
                                 input logic [3:0] iAa, input logic [15:0] iDia,
                                 input logic iCeb, input logic iWeb,
                                 input logic [3:0] iAb, input logic [15:0] iDib);
        cea = iCea;
        wea = iWea;
        aa  = iAa;
        dia = iDia;
        ceb = iCeb;
        web = iWeb;
        ab  = iAb;
        dib = iDib;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Count edges at which busy is high, bounded so a stuck busy cannot hang.
    task automatic countBusy(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 40 && (busy0 || busy1); k++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            tick();
        end
    endtask

    initial begin
        int   n0;
        int   n1;
        int   nClr;
        logic [15:0] prevA;
        logic [15:0] prevB;

        vecs[0]  = '{1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd5, 16'h0000, 16'h0000, 16'h1234};
        vecs[2]  = '{1'b1, 1'b1, 4'd7, 16'h0F0F, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h1234};
        vecs[3]  = '{1'b1, 1'b1, 4'd3, 16'h7777, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h1234};
        vecs[4]  = '{1'b1, 1'b1, 4'd3, 16'hAAAA, 1'b1, 1'b1, 4'd3, 16'h5555, 16'h7777, 16'h7777};
        vecs[5]  = '{1'b1, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b0, 4'd3, 16'h0000, 16'hAAAA, 16'hAAAA};
        vecs[6]  = '{1'b1, 1'b1, 4'd7, 16'hF0F0, 1'b1, 1'b0, 4'd7, 16'h0000, 16'h0F0F, 16'h0F0F};
        vecs[7]  = '{1'b1, 1'b0, 4'd7, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 16'hF0F0, 16'h0F0F};
        vecs[8]  = '{1'b1, 1'b0, 4'd9, 16'h0000, 1'b1, 1'b1, 4'd9, 16'hCAFE, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 4'd9, 16'h0000, 1'b1, 1'b0, 4'd5, 16'h0000, 16'hCAFE, 16'h1234};
        vecs[10] = '{1'b0, 1'b1, 4'd5, 16'h9999, 1'b1, 1'b0, 4'd3, 16'h0000, 16'hCAFE, 16'hAAAA};
        vecs[11] = '{1'b1, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h1234, 16'hAAAA};

        idleInputs();
        clr = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        // Reset state while rst is held.
        checkOutput("rst busy0", busy0, 1'b1);
        checkOutput("rst busy1", busy1, 1'b1);
        checkOutput("rst doa0", doa0, 16'h0000);
        checkOutput("rst dob0", dob0, 16'h0000);
        checkOutput("rst doa1", doa1, 16'h0000);
        checkOutput("rst dob1", dob1, 16'h0000);

        rst = 1'b0;
        countBusy(n0, n1);
        checkOutput("init clear edges0", n0, 16);
        checkOutput("init clear edges1", n1, 16);

        // Fill the whole array with ones, confirm, then reset and re-read.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 4'(i), 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd15, 16'h0000);
        checkOutput("fill doa0", doa0, 16'hFFFF);
        checkOutput("fill dob0", dob0, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
        checkOutput("fill doa1", doa1, 16'hFFFF);
        checkOutput("fill dob1", dob1, 16'hFFFF);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        countBusy(n0, n1);
        checkOutput("fill clear edges0", n0, 16);
        checkOutput("fill clear edges1", n1, 16);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i), 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
            checkOutput($sformatf("cleared doa0 a%0d", i), doa0, 16'h0000);
            checkOutput($sformatf("cleared doa1 a%0d", i), doa1, 16'h0000);
        end
        idleInputs();
        tick();

        // Table of single-cycle accesses; OREG = 1 lags by one edge.
        prevA = 16'h0000;
        prevB = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].cea, vecs[i].wea, vecs[i].aa, vecs[i].dia,
                          vecs[i].ceb, vecs[i].web, vecs[i].ab, vecs[i].dib);
            checkOutput($sformatf("vec%0d doa0", i), doa0, vecs[i].expA);
            checkOutput($sformatf("vec%0d dob0", i), dob0, vecs[i].expB);
            checkOutput($sformatf("vec%0d doa1", i), doa1, prevA);
            checkOutput($sformatf("vec%0d dob1", i), dob1, prevB);
            prevA = vecs[i].expA;
            prevB = vecs[i].expB;
        end

        // clr during traffic: the port B write on the clr edge is dropped.
        applyStimulus(1'b1, 1'b1, 4'd2, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
        checkOutput("beef rd doa0", doa0, 16'hBEEF);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd9, 16'h1111);
        clr = 1'b0;
        idleInputs();
        checkOutput("clr edge busy0", busy0, 1'b1);
        checkOutput("clr edge busy1", busy1, 1'b1);
        checkOutput("clr edge dob0 hold", dob0, 16'hAAAA);
        checkOutput("clr edge doa0 hold", doa0, 16'hBEEF);

        nClr = 1;
        for (int k = 0; k < 40 && busy0; k++) begin
            clr = (nClr == 6);
            tick();
            nClr++;
            if (nClr == 4) begin
                checkOutput("clearing doa0", doa0, 16'h0000);
                checkOutput("clearing dob0", dob0, 16'h0000);
                checkOutput("clearing doa1", doa1, 16'h0000);
                checkOutput("clearing dob1", dob1, 16'h0000);
            end
        end
        clr = 1'b0;
        checkOutput("clr busy edges", nClr, 17);
        checkOutput("clr done busy1", busy1, 1'b0);

        applyStimulus(1'b1, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b0, 4'd9, 16'h0000);
        checkOutput("post clr a2 doa0", doa0, 16'h0000);
        checkOutput("post clr a9 dob0", dob0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
        checkOutput("post clr a2 doa1", doa1, 16'h0000);
        checkOutput("post clr a9 dob1", dob1, 16'h0000);

        // rst six edges into a clear: immediate reset, then a full restart.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        rst = 1'b1;
        #2;
        checkOutput("midclr rst busy0", busy0, 1'b1);
        checkOutput("midclr rst busy1", busy1, 1'b1);
        checkOutput("midclr rst doa0", doa0, 16'h0000);
        checkOutput("midclr rst dob1", dob1, 16'h0000);
        tick();
        rst = 1'b0;
        countBusy(n0, n1);
        checkOutput("midclr restart edges0", n0, 16);
        checkOutput("midclr restart edges1", n1, 16);

        // rst during live read data: outputs must drop without a clock edge.
        applyStimulus(1'b1, 1'b1, 4'd1, 16'h4321, 1'b0, 1'b0, 4'd0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0, 4'd1, 16'h0000);
        checkOutput("live doa0", doa0, 16'h4321);
        checkOutput("live dob0", dob0, 16'h4321);
        applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
        checkOutput("live doa1", doa1, 16'h4321);
        checkOutput("live dob1", dob1, 16'h4321);
        rst = 1'b1;
        #2;
        checkOutput("async rst doa0", doa0, 16'h0000);
        checkOutput("async rst dob0", dob0, 16'h0000);
        checkOutput("async rst doa1", doa1, 16'h0000);
        checkOutput("async rst dob1", dob1, 16'h0000);
        checkOutput("async rst busy0", busy0, 1'b1);
        checkOutput("async rst busy1", busy1, 1'b1);
        tick();
        rst = 1'b0;
        countBusy(n0, n1);
        checkOutput("final clear edges0", n0, 16);
        checkOutput("final clear edges1", n1, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
